// File: rtl/a_rom_pkg.sv
// Shared A-matrix geometry and fetch-controller state encoding.
// Imported by the A/B fetch controllers, the coefficient ROM and the MAC datapath.
package a_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  localparam int COEF_W       = 7;
  localparam int A_NUM_WORDS  = 8;
  localparam int A_NUM_PASSES = 4;
  localparam int A_ADDR_STEP  = 2;

  // Index counters keep at least one bit so single-word or single-pass geometries stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/a_rom_fetch_ctrl_if.sv
// ROM address/data and downstream word stream of the A-side fetch controller.
// master = controller side, slave = ROM/datapath side.
interface a_rom_fetch_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 14,
  parameter int WIDX_W = 3,
  parameter int PIDX_W = 2
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] a_data;
  logic              a_valid;
  logic              a_ready;
  logic              a_last;
  logic [WIDX_W-1:0] word_idx;
  logic [PIDX_W-1:0] pass_idx;

  modport master (
    output rom_addr, a_data, a_valid, a_last, word_idx, pass_idx,
    input  rom_data, a_ready
  );

  modport slave (
    input  rom_addr, a_data, a_valid, a_last, word_idx, pass_idx,
    output rom_data, a_ready
  );
endinterface

// File: rtl/a_rom_idx_cnt.sv
// Two-level (word within pass, pass within run) wrap counter with clear and increment.
// Shared by the A-side and B-side fetch controllers.
module a_rom_idx_cnt
  import a_rom_pkg::*;
#(
  parameter int NUM_WORDS  = A_NUM_WORDS,
  parameter int NUM_PASSES = A_NUM_PASSES,
  parameter int WIDX_W     = idx_w(NUM_WORDS),
  parameter int PIDX_W     = idx_w(NUM_PASSES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [WIDX_W-1:0] word_idx,
  output logic [PIDX_W-1:0] pass_idx,
  output logic              word_last,
  output logic              run_last
);

  logic pass_last;

  assign word_last = (word_idx == WIDX_W'(NUM_WORDS - 1));
  assign pass_last = (pass_idx == PIDX_W'(NUM_PASSES - 1));
  assign run_last  = word_last && pass_last;

  // Incrementing past the final word of the final pass wraps both levels back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_idx <= '0;
      pass_idx <= '0;
    end else if (inc) begin
      if (word_last) begin
        word_idx <= '0;
        pass_idx <= pass_last ? '0 : pass_idx + PIDX_W'(1);
      end else begin
        word_idx <= word_idx + WIDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/a_rom_fetch_ctrl.sv
// A-matrix ROM sequencer: sweeps the coefficient address range once per pass and
// streams each registered ROM word downstream over valid/ready, one word per two cycles.
module a_rom_fetch_ctrl
  import a_rom_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 14,
  parameter int NUM_WORDS  = A_NUM_WORDS,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_STEP  = A_ADDR_STEP,
  parameter int NUM_PASSES = A_NUM_PASSES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  a_rom_fetch_ctrl_if.master bus
);

  localparam int WIDX_W = idx_w(NUM_WORDS);
  localparam int PIDX_W = idx_w(NUM_PASSES);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] FETCH   = ST_FETCH;
  localparam logic [1:0] PRESENT = ST_PRESENT;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [1:0] state;
  logic       xfer;
  logic       cnt_clr;
  logic       word_last;
  logic       run_last;

  assign xfer    = (state == PRESENT) && bus.a_ready;
  assign cnt_clr = (state == IDLE) && start;

  a_rom_idx_cnt #(
    .NUM_WORDS (NUM_WORDS),
    .NUM_PASSES(NUM_PASSES),
    .WIDX_W    (WIDX_W),
    .PIDX_W    (PIDX_W)
  ) u_idx_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (xfer),
    .word_idx (bus.word_idx),
    .pass_idx (bus.pass_idx),
    .word_last(word_last),
    .run_last (run_last)
  );

  // The ROM output lags rom_addr by one cycle, hence a FETCH cycle before every PRESENT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.rom_addr <= BASE;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= FETCH;
            bus.rom_addr <= BASE;
          end
        end
        FETCH: state <= PRESENT;
        PRESENT: begin
          if (xfer) begin
            if (!word_last) begin
              bus.rom_addr <= bus.rom_addr + STEP;
              state        <= FETCH;
            end else if (!run_last) begin
              bus.rom_addr <= BASE;
              state        <= FETCH;
            end else begin
              bus.rom_addr <= BASE;
              state        <= IDLE;
              done         <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_data  = bus.rom_data;
  assign bus.a_valid = (state == PRESENT);
  assign bus.a_last  = (state == PRESENT) && word_last;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_a_rom_fetch_ctrl.sv
// Directed bench for a_rom_fetch_ctrl: default geometry plus a 3-word, 1-pass wrapping instance.
module tb_a_rom_fetch_ctrl;
  import a_rom_pkg::*;

  logic clk = 1'b0;
  logic rst, start, s_start;
  logic busy, done, s_busy, s_done;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cyc0 = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  a_rom_fetch_ctrl_if #(.ADDR_W(4), .DATA_W(14), .WIDX_W(3), .PIDX_W(2)) u_if ();
  a_rom_fetch_ctrl_if #(.ADDR_W(4), .DATA_W(14), .WIDX_W(2), .PIDX_W(1)) s_if ();

  a_rom_fetch_ctrl u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (u_if.master)
  );

  a_rom_fetch_ctrl #(
    .ADDR_W(4), .DATA_W(14), .NUM_WORDS(3), .ADDR_BASE(14), .ADDR_STEP(2), .NUM_PASSES(1)
  ) s_dut (
    .clk  (clk),
    .rst  (rst),
    .start(s_start),
    .busy (s_busy),
    .done (s_done),
    .bus  (s_if.master)
  );

  function automatic logic [13:0] rom_word(input logic [3:0] a);
    return {a, 3'b101, ~a, 3'b011};
  endfunction

  // Registered ROM models, one per instance.
  always @(posedge clk) begin
    u_if.rom_data <= rom_word(u_if.rom_addr);
    s_if.rom_data <= rom_word(s_if.rom_addr);
  end

  always @(posedge clk) begin
    if (u_if.a_valid && u_if.a_ready) xfer_cnt <= xfer_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"},  u_if.rom_addr, 0);
    chk({tag, "_word"},  u_if.word_idx, 0);
    chk({tag, "_pass"},  u_if.pass_idx, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, u_if.a_valid, 0);
    chk({tag, "_last"},  u_if.a_last, 0);
  endtask

  // Re-pulses start on the relative edges ra/rb of the current run.
  task automatic drive_start(input int ra, input int rb);
    start = ((cyc + 1 - cyc0) == ra) || ((cyc + 1 - cyc0) == rb);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc0 = cyc;
  endtask

  // Walks one run from the first FETCH cycle; optional stall, start re-pulses, or reset abort.
  task automatic run_body(input int hold_p, input int hold_w, input int hold_n,
                          input int ra, input int rb, input int abort_p, input int abort_w);
    bit stop;
    stop = 1'b0;
    for (int p = 0; p < 4 && !stop; p++) begin
      for (int w = 0; w < 8 && !stop; w++) begin
        logic [3:0] ea;
        ea = 4'(2 * w);
        chk("fetch_valid", u_if.a_valid, 0);
        chk("fetch_busy", busy, 1);
        drive_start(ra, rb);
        step();
        start = 1'b0;
        chk("pres_valid", u_if.a_valid, 1);
        chk("pres_addr", u_if.rom_addr, ea);
        chk("pres_word", u_if.word_idx, w);
        chk("pres_pass", u_if.pass_idx, p);
        chk("pres_last", u_if.a_last, (w == 7));
        chk("pres_data", u_if.a_data, rom_word(ea));
        chk("pres_done", done, 0);
        if (p == abort_p && w == abort_w) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          stop = 1'b1;
        end else begin
          if (p == hold_p && w == hold_w) begin
            u_if.a_ready = 1'b0;
            for (int k = 0; k < hold_n; k++) begin
              step();
              chk("hold_valid", u_if.a_valid, 1);
              chk("hold_addr", u_if.rom_addr, ea);
              chk("hold_word", u_if.word_idx, w);
              chk("hold_pass", u_if.pass_idx, p);
              chk("hold_data", u_if.a_data, rom_word(ea));
            end
            u_if.a_ready = 1'b1;
          end
          drive_start(ra, rb);
          step();
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic finish_run(input int stall, input int x0, input int d0, input bit b2b);
    chk("done_latency", cyc - cyc0, 64 + stall);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_valid", u_if.a_valid, 0);
    chk("end_addr", u_if.rom_addr, 0);
    chk("end_word", u_if.word_idx, 0);
    chk("end_pass", u_if.pass_idx, 0);
    chk("xfer_count", xfer_cnt - x0, 32);
    start = b2b;
    step();
    start = 1'b0;
    if (b2b) cyc0 = cyc;
    chk("done_pulse_width", done, 0);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int x0, d0;
    rst = 1'b1;
    start = 1'b0;
    s_start = 1'b0;
    u_if.a_ready = 1'b1;
    s_if.a_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    check_reset("reset");
    chk("reset_s_addr", s_if.rom_addr, 14);
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Basic run with a_ready held high.
    x0 = xfer_cnt; d0 = done_cnt;
    do_start();
    run_body(-1, -1, 0, -1, -1, -1, -1);
    finish_run(0, x0, d0, 1'b0);

    // Five-cycle stall on pass 1, word 3 (address 6).
    x0 = xfer_cnt; d0 = done_cnt;
    do_start();
    run_body(1, 3, 5, -1, -1, -1, -1);
    finish_run(5, x0, d0, 1'b0);

    // start re-pulsed mid-run is ignored.
    x0 = xfer_cnt; d0 = done_cnt;
    do_start();
    run_body(-1, -1, 0, 10, 30, -1, -1);
    finish_run(0, x0, d0, 1'b0);

    // Reset during pass 2, word 5, then a clean run.
    d0 = done_cnt;
    do_start();
    run_body(-1, -1, 0, -1, -1, 2, 5);
    check_reset("abort");
    step();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_valid", u_if.a_valid, 0);
    x0 = xfer_cnt; d0 = done_cnt;
    do_start();
    run_body(-1, -1, 0, -1, -1, -1, -1);
    finish_run(0, x0, d0, 1'b0);

    // Back-to-back: start coincides with the done pulse.
    x0 = xfer_cnt; d0 = done_cnt;
    do_start();
    run_body(-1, -1, 0, -1, -1, -1, -1);
    finish_run(0, x0, d0, 1'b1);
    chk("b2b_busy", busy, 1);
    x0 = xfer_cnt; d0 = done_cnt;
    run_body(-1, -1, 0, -1, -1, -1, -1);
    finish_run(0, x0, d0, 1'b0);

    // Single-pass, three-word instance starting at 14 with address wrap.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    cyc0 = cyc;
    for (int w = 0; w < 3; w++) begin
      logic [3:0] ea;
      ea = 4'(14 + 2 * w);
      chk("s_fetch_valid", s_if.a_valid, 0);
      step();
      chk("s_valid", s_if.a_valid, 1);
      chk("s_addr", s_if.rom_addr, ea);
      chk("s_word", s_if.word_idx, w);
      chk("s_pass", s_if.pass_idx, 0);
      chk("s_last", s_if.a_last, (w == 2));
      chk("s_data", s_if.a_data, rom_word(ea));
      step();
    end
    chk("s_done_latency", cyc - cyc0, 6);
    chk("s_done", s_done, 1);
    chk("s_busy", s_busy, 0);
    chk("s_end_addr", s_if.rom_addr, 14);
    step();
    chk("s_done_pulse", s_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
